joint_histogram_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the output-stage joint-histogram memory, NUM_CH banks of NUM_BINS bins.

---
 rtl/joint_histogram_seq_ctrl.sv | 166 ++++++++++++++++
 tb/tb_joint_histogram_seq_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joint_histogram_seq_ctrl.sv
// Frame sequencer for a banked joint-histogram memory: optional bin clear, counting,
// flow-controlled multi-bank read-back and a one-cycle finish pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start_i
// ST_CLEAR  | writing zero to every {ch,addr}, one bin per cycle
// ST_COUNT  | incrementer enabled until the last pixel is reported
// ST_PRE_RD | bubble so the final increment lands before reading
// ST_READ   | one read per cycle granted by rd_ready_i
// ST_DRAIN  | waiting for the last read datum to come out of the memory
// ST_FIN    | finish pulse
module joint_histogram_seq_ctrl #(
   parameter int NUM_BINS = 256,
   parameter int NUM_CH   = 1,
   parameter bit CLR_EN   = 1'b1,
   localparam int BIN_W   = $clog2(NUM_BINS),
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             progress_done_i,
   input  logic             abort_i,
   input  logic             rd_ready_i,
   output logic             clr_en_o,
   output logic             count_en_o,
   output logic             rd_en_o,
   output logic [BIN_W-1:0] addr_o,
   output logic [CH_W-1:0]  ch_o,
   output logic             rd_valid_o,
   output logic             rd_last_o,
   output logic             done_o,
   output logic             finish_o,
   output logic             busy_o
);

   localparam logic [BIN_W-1:0] ADDR_LAST = BIN_W'(NUM_BINS - 1);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_COUNT  = 3'd2,
      ST_PRE_RD = 3'd3,
      ST_READ   = 3'd4,
      ST_DRAIN  = 3'd5,
      ST_FIN    = 3'd6
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             pending;
   logic             pending_nxt;
   logic             at_last;
   logic             advance;
   logic             hold;
   logic [BIN_W-1:0] addr_nxt;
   logic [CH_W-1:0]  ch_nxt;
   logic             clr_en_d;
   logic             count_en_d;
   logic             rd_en_d;
   logic             rd_valid_d;
   logic             rd_last_d;
   logic             done_d;
   logic             finish_d;
   logic             busy_d;

   assign at_last = (ch_o == CH_LAST) && (addr_o == ADDR_LAST);

   // State, pointer, pending flag and every output are registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         pending    <= 1'b0;
         addr_o     <= '0;
         ch_o       <= '0;
         clr_en_o   <= 1'b0;
         count_en_o <= 1'b0;
         rd_en_o    <= 1'b0;
         rd_valid_o <= 1'b0;
         rd_last_o  <= 1'b0;
         done_o     <= 1'b0;
         finish_o   <= 1'b0;
         busy_o     <= 1'b0;
      end else begin
         state      <= state_nxt;
         pending    <= pending_nxt;
         addr_o     <= addr_nxt;
         ch_o       <= ch_nxt;
         clr_en_o   <= clr_en_d;
         count_en_o <= count_en_d;
         rd_en_o    <= rd_en_d;
         rd_valid_o <= rd_valid_d;
         rd_last_o  <= rd_last_d;
         done_o     <= done_d;
         finish_o   <= finish_d;
         busy_o     <= busy_d;
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort_i) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (start_i) state_nxt = CLR_EN ? ST_CLEAR : ST_COUNT;
            ST_CLEAR:  if (at_last) state_nxt = ST_COUNT;
            ST_COUNT:  if (progress_done_i || pending) state_nxt = ST_PRE_RD;
            ST_PRE_RD: state_nxt = ST_READ;
            ST_READ:   if (rd_en_o && at_last) state_nxt = ST_DRAIN;
            ST_DRAIN:  state_nxt = ST_FIN;
            ST_FIN:    state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
         endcase
      end
   end

   // Outputs are decoded from the state being entered so they line up with it.
   always_comb begin
      clr_en_d   = (state_nxt == ST_CLEAR);
      count_en_d = (state_nxt == ST_COUNT);
      rd_en_d    = (state_nxt == ST_READ) && rd_ready_i;
      rd_valid_d = rd_en_o && !abort_i;
      rd_last_d  = rd_en_o && at_last && !abort_i;
      done_d     = (state_nxt == ST_READ) || (state_nxt == ST_DRAIN);
      finish_d   = (state_nxt == ST_FIN);
      busy_d     = (state_nxt != ST_IDLE);
   end

   // A progress_done pulse that arrives while still clearing must not be lost.
   always_comb begin
      pending_nxt = pending;
      if (abort_i) begin
         pending_nxt = 1'b0;
      end else if ((state == ST_CLEAR) && progress_done_i) begin
         pending_nxt = 1'b1;
      end else if (state_nxt == ST_PRE_RD) begin
         pending_nxt = 1'b0;
      end
   end

   // {ch,addr} walks bins addr-major within a bank; it only moves on a clear
   // cycle or an issued read, holds during read stalls and is zero elsewhere.
   always_comb begin
      advance  = ((state == ST_CLEAR) && (state_nxt == ST_CLEAR)) ||
                 ((state == ST_READ) && (state_nxt == ST_READ) && rd_en_o);
      hold     = (state == ST_READ) && (state_nxt == ST_READ) && !rd_en_o;
      addr_nxt = '0;
      ch_nxt   = '0;
      if (advance) begin
         if (addr_o == ADDR_LAST) begin
            addr_nxt = '0;
            ch_nxt   = (ch_o == CH_LAST) ? '0 : ch_o + CH_W'(1);
         end else begin
            addr_nxt = addr_o + BIN_W'(1);
            ch_nxt   = ch_o;
         end
      end else if (hold) begin
         addr_nxt = addr_o;
         ch_nxt   = ch_o;
      end
   end

endmodule

// File: tb/tb_joint_histogram_seq_ctrl.sv
// Bench for joint_histogram_seq_ctrl: two instances (4x2 with clear, 5x3 without)
// share one stimulus stream and are compared every cycle against a frame-level model.
module tb_joint_histogram_seq_ctrl;

   localparam int P_IDLE = 0, P_CLEAR = 1, P_COUNT = 2, P_PRE = 3,
                  P_READ = 4, P_DRAIN = 5, P_FIN = 6;

   typedef struct packed {
      logic        clr;
      logic        cnt;
      logic        rd;
      logic        val;
      logic        last;
      logic        done;
      logic        fin;
      logic        busy;
      logic [31:0] addr;
      logic [31:0] ch;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n, start, pd, abort, rr;
   always #5 clk = ~clk;

   logic       a_clr, a_cnt, a_rd, a_val, a_last, a_done, a_fin, a_busy;
   logic [1:0] a_addr;
   logic [0:0] a_ch;
   logic       b_clr, b_cnt, b_rd, b_val, b_last, b_done, b_fin, b_busy;
   logic [2:0] b_addr;
   logic [1:0] b_ch;

   joint_histogram_seq_ctrl #(.NUM_BINS(4), .NUM_CH(2), .CLR_EN(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start_i(start), .progress_done_i(pd),
      .abort_i(abort), .rd_ready_i(rr), .clr_en_o(a_clr), .count_en_o(a_cnt),
      .rd_en_o(a_rd), .addr_o(a_addr), .ch_o(a_ch), .rd_valid_o(a_val),
      .rd_last_o(a_last), .done_o(a_done), .finish_o(a_fin), .busy_o(a_busy));

   joint_histogram_seq_ctrl #(.NUM_BINS(5), .NUM_CH(3), .CLR_EN(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .start_i(start), .progress_done_i(pd),
      .abort_i(abort), .rd_ready_i(rr), .clr_en_o(b_clr), .count_en_o(b_cnt),
      .rd_en_o(b_rd), .addr_o(b_addr), .ch_o(b_ch), .rd_valid_o(b_val),
      .rd_last_o(b_last), .done_o(b_done), .finish_o(b_fin), .busy_o(b_busy));

   obs_t obs [2];
   assign obs[0] = {a_clr, a_cnt, a_rd, a_val, a_last, a_done, a_fin, a_busy,
                    32'(a_addr), 32'(a_ch)};
   assign obs[1] = {b_clr, b_cnt, b_rd, b_val, b_last, b_done, b_fin, b_busy,
                    32'(b_addr), 32'(b_ch)};

   int checks = 0;
   int errors = 0;

   int nb [2] = '{4, 5};
   int nc [2] = '{2, 3};
   bit ce [2] = '{1'b1, 1'b0};

   // Model: phase plus a linear bin index; ch/addr are index div/mod bins.
   int ph [2];
   int idx [2];
   bit pend [2];
   bit m_rd [2];
   bit m_val [2];
   bit m_last [2];

   int seen [2][15];
   int vcnt [2];
   int lcnt [2];

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic sb_clear(input int k);
      for (int b = 0; b < 15; b++) seen[k][b] = 0;
      vcnt[k] = 0;
      lcnt[k] = 0;
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         ph[k] = P_IDLE; idx[k] = 0; pend[k] = 0;
         m_rd[k] = 0; m_val[k] = 0; m_last[k] = 0;
         sb_clear(k);
      end
   endtask

   task automatic model_step(input int k, input bit s, input bit p, input bit a, input bit r);
      int total;
      bit nval, nlast;
      total = nb[k] * nc[k];
      nval  = m_rd[k];
      nlast = m_rd[k] && (idx[k] == total - 1);
      if (a) begin
         ph[k] = P_IDLE; idx[k] = 0; pend[k] = 0;
         m_rd[k] = 0; m_val[k] = 0; m_last[k] = 0;
      end else begin
         case (ph[k])
            P_IDLE: if (s) begin
               ph[k] = ce[k] ? P_CLEAR : P_COUNT;
               idx[k] = 0;
               sb_clear(k);
            end
            P_CLEAR: begin
               if (p) pend[k] = 1;
               if (idx[k] == total - 1) begin ph[k] = P_COUNT; idx[k] = 0; end
               else idx[k]++;
            end
            P_COUNT: if (p || pend[k]) begin ph[k] = P_PRE; pend[k] = 0; end
            P_PRE:   begin ph[k] = P_READ; idx[k] = 0; end
            P_READ:  if (m_rd[k]) begin
               if (idx[k] == total - 1) begin ph[k] = P_DRAIN; idx[k] = 0; end
               else idx[k]++;
            end
            P_DRAIN: ph[k] = P_FIN;
            default: ph[k] = P_IDLE;
         endcase
         m_rd[k]   = (ph[k] == P_READ) && r;
         m_val[k]  = nval;
         m_last[k] = nlast;
      end
   endtask

   task automatic check_dut(input int k);
      int total, b;
      string d;
      obs_t o;
      o = obs[k];
      d = (k == 0) ? "a" : "b";
      total = nb[k] * nc[k];
      chk({d, " clr_en"},   o.clr,  ph[k] == P_CLEAR);
      chk({d, " count_en"}, o.cnt,  ph[k] == P_COUNT);
      chk({d, " rd_en"},    o.rd,   m_rd[k]);
      chk({d, " rd_valid"}, o.val,  m_val[k]);
      chk({d, " rd_last"},  o.last, m_last[k]);
      chk({d, " done"},     o.done, (ph[k] == P_READ) || (ph[k] == P_DRAIN));
      chk({d, " finish"},   o.fin,  ph[k] == P_FIN);
      chk({d, " busy"},     o.busy, ph[k] != P_IDLE);
      chk({d, " addr"},     o.addr, 32'(idx[k] % nb[k]));
      chk({d, " ch"},       o.ch,   32'(idx[k] / nb[k]));
      if (o.rd === 1'b1) begin
         b = int'(o.ch) * nb[k] + int'(o.addr);
         if (b >= 0 && b < total) seen[k][b]++;
      end
      if (o.val === 1'b1) vcnt[k]++;
      if (o.last === 1'b1) lcnt[k]++;
      if (o.fin === 1'b1) begin
         chk({d, " frame_valid_count"}, vcnt[k], total);
         chk({d, " frame_last_count"}, lcnt[k], 1);
         for (int i = 0; i < total; i++)
            chk($sformatf("%s bin%0d_reads", d, i), seen[k][i], 1);
      end
   endtask

   task automatic cyc(input bit s, input bit p, input bit a, input bit r);
      start = s; pd = p; abort = a; rr = r;
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, s, p, a, r);
      @(negedge clk);
      for (int k = 0; k < 2; k++) check_dut(k);
      start = 0; pd = 0; abort = 0;
   endtask

   // mode 0: random ready, 1: ready 1,0,0 repeating, 2: always ready, 3: random with noise
   task automatic run_until_idle(input string tag, input int mode);
      bit r, p, a;
      for (int i = 0; i < 400; i++) begin
         if (ph[0] == P_IDLE && ph[1] == P_IDLE) break;
         r = (mode == 0 || mode == 3) ? 1'($urandom_range(0, 1)) :
             (mode == 1) ? (i % 3 == 0) : 1'b1;
         p = (mode == 3) && ($urandom_range(0, 7) == 0);
         a = (mode == 3) && ($urandom_range(0, 99) == 0);
         cyc(0, p, a, r);
      end
      chk({tag, " idle_timeout"}, a_busy | b_busy, 0);
   endtask

   initial begin
      bit reached;
      rst_n = 0; start = 0; pd = 0; abort = 0; rr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      for (int k = 0; k < 2; k++) check_dut(k);
      rst_n = 1;
      cyc(0, 0, 0, 0);

      // Frame 1: progress_done lands while A is still clearing.
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      run_until_idle("f1", 0);

      // Frame 2: start ignored in COUNT, read with ready pattern 1,0,0.
      cyc(1, 0, 0, 0);
      repeat (9) cyc(0, 0, 0, 0);
      chk("a in_count", a_cnt, 1);
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0);
      run_until_idle("f2", 1);

      // Frame 3: abort while A reads bin 2, then a clean frame.
      cyc(1, 0, 0, 1);
      repeat (8) cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      reached = 0;
      for (int i = 0; i < 50; i++) begin
         if (ph[0] == P_READ && m_rd[0] && idx[0] == 2) begin reached = 1; break; end
         cyc(0, 0, 0, 1);
      end
      chk("abort_reach_addr2", {a_rd, 30'(a_addr), reached}, {1'b1, 30'd2, 1'b1});
      cyc(0, 0, 1, 1);
      chk("abort a_busy", a_busy, 0);
      chk("abort a_rd_valid", a_val, 0);
      repeat (4) cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      repeat (10) cyc(0, 0, 0, 1);
      cyc(0, 1, 0, 1);
      run_until_idle("f3", 2);

      // Asynchronous reset in the middle of A's clear sweep.
      cyc(1, 0, 0, 1);
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("rst a_flags", {a_clr, a_cnt, a_rd, a_val, a_last, a_done, a_fin, a_busy}, 0);
      chk("rst a_ptr", {a_addr, a_ch}, 0);
      chk("rst b_flags", {b_clr, b_cnt, b_rd, b_val, b_last, b_done, b_fin, b_busy}, 0);
      chk("rst b_ptr", {b_addr, b_ch}, 0);
      model_reset();
      @(negedge clk);
      rst_n = 1;
      cyc(0, 0, 0, 0);

      // Randomised frames with random pd timing, ready and rare aborts.
      for (int f = 0; f < 20; f++) begin
         cyc(1, 0, 0, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 12)) cyc(0, 0, 0, 1'($urandom_range(0, 1)));
         cyc(0, 1, 0, 1'($urandom_range(0, 1)));
         run_until_idle($sformatf("rf%0d", f), 3);
         cyc(0, 0, 0, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
